// File: rtl/field_assembler.sv
// Packs NUM_FIELDS independently produced sub-words into one word, emitted on a
// registered valid/ready port; flush emits a partially filled word with its mask.
module field_assembler #(
   parameter int NUM_FIELDS = 2,
   parameter int FIELD_W    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_FIELDS-1:0]         fld_valid,
   input  logic [NUM_FIELDS*FIELD_W-1:0] fld_data,
   output logic [NUM_FIELDS-1:0]         fld_ready,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
   output logic [NUM_FIELDS-1:0]         out_mask
);

   localparam int DW = NUM_FIELDS * FIELD_W;

   typedef enum logic {COLLECT, FULL} state_t;

   state_t                state, state_nxt;
   logic [DW-1:0]         data_nxt;
   logic [NUM_FIELDS-1:0] mask_nxt;
   logic [NUM_FIELDS-1:0] accepted;
   logic [NUM_FIELDS-1:0] merged;

   // While collecting, out_mask doubles as the filled mask, so slots only open
   // once; while full, producers are only let in alongside a consumer handshake.
   always_comb begin
      fld_ready = ~out_mask;
      if (state == FULL) begin
         fld_ready = {NUM_FIELDS{out_ready}};
      end
   end

   assign accepted  = fld_valid & fld_ready;
   assign merged    = out_mask | accepted;
   assign out_valid = (state == FULL);

   always_comb begin
      state_nxt = state;
      data_nxt  = out_data;
      mask_nxt  = out_mask;
      case (state)
         COLLECT: begin
            mask_nxt = merged;
            for (int i = 0; i < NUM_FIELDS; i++) begin
               if (accepted[i]) begin
                  data_nxt[i*FIELD_W +: FIELD_W] = fld_data[i*FIELD_W +: FIELD_W];
               end
            end
            if ((&merged) || (flush && (|merged))) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            // Handshake: fields arriving in the same cycle seed the next word
            if (out_ready) begin
               mask_nxt = accepted;
               for (int i = 0; i < NUM_FIELDS; i++) begin
                  data_nxt[i*FIELD_W +: FIELD_W] =
                     accepted[i] ? fld_data[i*FIELD_W +: FIELD_W] : {FIELD_W{1'b0}};
               end
               if ((&accepted) || (flush && (|accepted))) begin
                  state_nxt = FULL;
               end else begin
                  state_nxt = COLLECT;
               end
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= COLLECT;
         out_data <= '0;
         out_mask <= '0;
      end else begin
         state    <= state_nxt;
         out_data <= data_nxt;
         out_mask <= mask_nxt;
      end
   end

endmodule

// File: tb/tb_field_assembler.sv
// Self-checking bench for field_assembler: directed scenarios with literal
// expectations plus randomized traffic compared against a per-field model.
module tb_field_assembler;

   localparam int NF = 2;
   localparam int W  = 2;
   localparam int DW = NF * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NF-1:0] fld_valid;
   logic [DW-1:0] fld_data;
   logic [NF-1:0] fld_ready;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [NF-1:0] out_mask;

   int checks = 0;
   int errors = 0;

   // Model: a word is an array of field slots with a presence flag each
   bit            m_valid;
   bit            m_have  [NF];
   logic [W-1:0]  m_field [NF];
   bit            n_valid;
   bit            n_have  [NF];
   logic [W-1:0]  n_field [NF];

   field_assembler #(.NUM_FIELDS(NF), .FIELD_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fld_valid (fld_valid),
      .fld_data  (fld_data),
      .fld_ready (fld_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NF-1:0] modelReady();
      logic [NF-1:0] r;
      for (int i = 0; i < NF; i++) r[i] = m_valid ? out_ready : !m_have[i];
      return r;
   endfunction

   function automatic logic [DW-1:0] modelData();
      logic [DW-1:0] d = '0;
      for (int i = 0; i < NF; i++) if (m_have[i]) d[i*W +: W] = m_field[i];
      return d;
   endfunction

   function automatic logic [NF-1:0] modelMask();
      logic [NF-1:0] m;
      for (int i = 0; i < NF; i++) m[i] = m_have[i];
      return m;
   endfunction

   task automatic modelReset();
      m_valid = 0;
      for (int i = 0; i < NF; i++) begin
         m_have[i]  = 0;
         m_field[i] = '0;
      end
   endtask

   // Decide what the word looks like after the coming edge
   task automatic modelNext();
      logic [NF-1:0] rdy;
      int            nacc, total;
      rdy  = modelReady();
      nacc = 0;
      n_valid = m_valid;
      for (int i = 0; i < NF; i++) begin
         n_have[i]  = m_have[i];
         n_field[i] = m_field[i];
      end
      for (int i = 0; i < NF; i++) if (fld_valid[i] && rdy[i]) nacc++;
      if (!rst_n) begin
         n_valid = 0;
         for (int i = 0; i < NF; i++) begin
            n_have[i]  = 0;
            n_field[i] = '0;
         end
      end else if (!m_valid) begin
         total = 0;
         for (int i = 0; i < NF; i++) begin
            if (fld_valid[i] && rdy[i]) begin
               n_have[i]  = 1;
               n_field[i] = fld_data[i*W +: W];
            end
            if (n_have[i]) total++;
         end
         n_valid = (total == NF) || (flush && total > 0);
      end else if (out_ready) begin
         for (int i = 0; i < NF; i++) begin
            n_have[i]  = fld_valid[i];
            n_field[i] = fld_valid[i] ? fld_data[i*W +: W] : '0;
         end
         n_valid = (nacc == NF) || (flush && nacc > 0);
      end
   endtask

   task automatic stepCycle();
      modelNext();
      @(posedge clk);
      #1;
      m_valid = n_valid;
      for (int i = 0; i < NF; i++) begin
         m_have[i]  = n_have[i];
         m_field[i] = n_field[i];
      end
   endtask

   task automatic applyStimulus(input logic [NF-1:0] fv, input logic [DW-1:0] fd,
                                input logic fl, input logic ordy);
      fld_valid = fv;
      fld_data  = fd;
      flush     = fl;
      out_ready = ordy;
   endtask

   // Compare process: DUT against the model in the middle of every cycle
   always @(negedge clk) begin
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("fld_ready", 32'(fld_ready), 32'(modelReady()));
      if (m_valid) begin
         checkOutput("out_data", 32'(out_data), 32'(modelData()));
         checkOutput("out_mask", 32'(out_mask), 32'(modelMask()));
      end
   end

   initial begin
      modelReset();
      rst_n = 1'b0;
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b0);
      repeat (2) stepCycle();
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_data", 32'(out_data), 32'd0);
      checkOutput("reset out_mask", 32'(out_mask), 32'd0);
      rst_n = 1'b1;

      // T1: fields on separate cycles
      applyStimulus(2'b01, 4'b0001, 1'b0, 1'b0); stepCycle();
      checkOutput("T1 early valid", 32'(out_valid), 32'd0);
      applyStimulus(2'b10, 4'b1000, 1'b0, 1'b0); stepCycle();
      checkOutput("T1 out_valid", 32'(out_valid), 32'd1);
      checkOutput("T1 out_data", 32'(out_data), 32'b1001);
      checkOutput("T1 out_mask", 32'(out_mask), 32'b11);
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b1); stepCycle();

      // T2: both fields in one cycle
      applyStimulus(2'b11, 4'b0011, 1'b0, 1'b0);
      #1 checkOutput("T2 fld_ready", 32'(fld_ready), 32'b11);
      stepCycle();
      checkOutput("T2 out_data", 32'(out_data), 32'b0011);
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b1); stepCycle();

      // T3: second write to a filled slot stalls and lands in the next word
      applyStimulus(2'b01, 4'b0010, 1'b0, 1'b0); stepCycle();
      applyStimulus(2'b01, 4'b0001, 1'b0, 1'b0);
      #1 checkOutput("T3 fld_ready", 32'(fld_ready), 32'b10);
      stepCycle();
      checkOutput("T3 stalled valid", 32'(out_valid), 32'd0);
      applyStimulus(2'b11, 4'b0001, 1'b0, 1'b0); stepCycle();
      checkOutput("T3 first word", 32'(out_data), 32'b0010);
      applyStimulus(2'b01, 4'b0001, 1'b0, 1'b1); stepCycle();
      applyStimulus(2'b10, 4'b0100, 1'b0, 1'b0); stepCycle();
      checkOutput("T3 second word", 32'(out_data), 32'b0101);
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b1); stepCycle();

      // T4: consumer stall then back-to-back word
      applyStimulus(2'b11, 4'b1110, 1'b0, 1'b0); stepCycle();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b11, 4'b0101, 1'b0, 1'b0);
         #1 checkOutput("T4 stall ready", 32'(fld_ready), 32'b00);
         stepCycle();
         checkOutput("T4 held data", 32'(out_data), 32'b1110);
      end
      applyStimulus(2'b11, 4'b0101, 1'b0, 1'b1); stepCycle();
      checkOutput("T4 b2b valid", 32'(out_valid), 32'd1);
      checkOutput("T4 b2b data", 32'(out_data), 32'b0101);
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b1); stepCycle();

      // T5: partial flush, then flush of an empty word
      applyStimulus(2'b10, 4'b1100, 1'b0, 1'b0); stepCycle();
      applyStimulus(2'b00, 4'b0000, 1'b1, 1'b0); stepCycle();
      checkOutput("T5 flush data", 32'(out_data), 32'b1100);
      checkOutput("T5 flush mask", 32'(out_mask), 32'b10);
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b1); stepCycle();
      applyStimulus(2'b00, 4'b0000, 1'b1, 1'b1); stepCycle();
      checkOutput("T5 empty flush", 32'(out_valid), 32'd0);

      // T6: reset mid-word discards the partial word
      applyStimulus(2'b01, 4'b0011, 1'b0, 1'b0); stepCycle();
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("T6 reset valid", 32'(out_valid), 32'd0);
      checkOutput("T6 reset data", 32'(out_data), 32'd0);
      checkOutput("T6 reset mask", 32'(out_mask), 32'd0);
      stepCycle();
      rst_n = 1'b1;
      applyStimulus(2'b10, 4'b1000, 1'b0, 1'b0); stepCycle();
      checkOutput("T6 no emit", 32'(out_valid), 32'd0);
      applyStimulus(2'b01, 4'b0001, 1'b0, 1'b0); stepCycle();
      checkOutput("T6 fresh word", 32'(out_data), 32'b1001);
      applyStimulus(2'b00, 4'b0000, 1'b0, 1'b1); stepCycle();

      // Randomized traffic with occasional flushes, stalls and resets
      for (int n = 0; n < 600; n++) begin
         rst_n = 1'b1;
         applyStimulus(NF'($urandom), DW'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            modelReset();
         end
         stepCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
